// File: rtl/rc4_stream_xor_if.sv
// rc4_stream_xor_if: control, keystream, plaintext and ciphertext handshakes of the RC4 XOR stage.
interface rc4_stream_xor_if #(parameter int LEN_W = 16);
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic [LEN_W-1:0] drop_n;
    logic             ks_valid;
    logic [7:0]       ks_data;
    logic             ks_ready;
    logic             pt_valid;
    logic [7:0]       pt_data;
    logic             pt_ready;
    logic             ct_valid;
    logic [7:0]       ct_data;
    logic             ct_last;
    logic             ct_ready;
    logic             busy;
    logic             done;
    modport slave (
        input  start, msg_len, drop_n, ks_valid, ks_data, pt_valid, pt_data, ct_ready,
        output ks_ready, pt_ready, ct_valid, ct_data, ct_last, busy, done
    );
    modport master (
        output start, msg_len, drop_n, ks_valid, ks_data, pt_valid, pt_data, ct_ready,
        input  ks_ready, pt_ready, ct_valid, ct_data, ct_last, busy, done
    );
endinterface

// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: drops the first drop_n keystream bytes, then XORs buffered keystream with plaintext.
module rc4_stream_xor #(
    parameter int KS_DEPTH = 4,
    parameter int LEN_W    = 16
) (
    input logic             clk,
    input logic             rst,
    rc4_stream_xor_if.slave bus
);
    localparam int AW = $clog2(KS_DEPTH);
    localparam logic [LEN_W-1:0] ONE = 1;
    localparam logic [AW:0] PTR_ONE = 1;
    typedef enum logic [2:0] {IDLE, DISCARD, RUN, FLUSH, DONE} state_t;
    state_t state, state_nx;
    logic [LEN_W-1:0] rem, fetch, drop;
    logic [7:0] mem [KS_DEPTH];
    logic [AW:0] wp, rp;
    logic full, empty, ks_fire, pt_fire, ct_fire;
    logic ct_v, ct_l;
    logic [7:0] ct_d;
    // Extra pointer bit tells full from empty when the indices match.
    assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign empty = wp == rp;
    assign bus.ks_ready = state == DISCARD || (state == RUN && !full && fetch != '0);
    assign bus.pt_ready = state == RUN && !empty && rem != '0 && (!ct_v || bus.ct_ready);
    assign ks_fire = bus.ks_valid && bus.ks_ready;
    assign pt_fire = bus.pt_valid && bus.pt_ready;
    assign ct_fire = ct_v && bus.ct_ready;
    assign bus.ct_valid = ct_v;
    assign bus.ct_data = ct_d;
    assign bus.ct_last = ct_l;
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = bus.msg_len == '0 ? DONE : bus.drop_n != '0 ? DISCARD : RUN;
            DISCARD: if (ks_fire && drop == ONE) state_nx = RUN;
            RUN:     if (pt_fire && rem == ONE) state_nx = FLUSH;
            FLUSH:   if (ct_fire && ct_l) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            fetch <= '0;
            drop  <= '0;
            wp    <= '0;
            rp    <= '0;
            ct_v  <= 1'b0;
            ct_d  <= '0;
            ct_l  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.start) begin
                rem   <= bus.msg_len;
                fetch <= bus.msg_len;
                drop  <= bus.drop_n;
            end
            if (ks_fire && state == DISCARD) drop <= drop - ONE;
            if (ks_fire && state == RUN) begin
                wp    <= wp + PTR_ONE;
                fetch <= fetch - ONE;
            end
            if (pt_fire) begin
                rp   <= rp + PTR_ONE;
                rem  <= rem - ONE;
                ct_v <= 1'b1;
                ct_d <= bus.pt_data ^ mem[rp[AW-1:0]];
                ct_l <= rem == ONE;
            end else if (ct_fire) begin
                ct_v <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (ks_fire && state == RUN) mem[wp[AW-1:0]] <= bus.ks_data;
    end
endmodule

// File: tb/tb_rc4_stream_xor.sv
// tb_rc4_stream_xor: randomized scoreboard bench; expected bytes come from the plain RC4-drop XOR rule.
module tb_rc4_stream_xor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    rc4_stream_xor_if #(.LEN_W(16)) bus();
    rc4_stream_xor #(.KS_DEPTH(4), .LEN_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [7:0] ks_q[$], pt_q[$], stg_ks[$], stg_pt[$];
    logic [8:0] exp_q[$];
    int n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0;
    int ks_cnt = 0, pt_cnt = 0, ct_cnt = 0, done_cyc = 0, last_ct_cyc = 0, start_cyc = 0, d0 = 0;
    logic ks_hs = 1'b0, pt_hs = 1'b0, rdy_seen = 1'b0;
    logic pt_en = 1'b1, ct_hold = 1'b0, full_rate = 1'b0;
    logic stall_prev = 1'b0, stall_last = 1'b0;
    logic [7:0] stall_data = '0;
    logic [8:0] cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each ciphertext handshake.
    always @(negedge clk) begin
        logic [8:0] e;
        cyc++;
        ks_hs = bus.ks_valid && bus.ks_ready;
        pt_hs = bus.pt_valid && bus.pt_ready;
        if (ks_hs) ks_cnt++;
        if (pt_hs) pt_cnt++;
        if (bus.ks_ready || bus.pt_ready) rdy_seen = 1'b1;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (stall_prev && !rst)
            chk("ct_hold", {23'b0, bus.ct_valid, bus.ct_last, bus.ct_data}, {23'b0, 1'b1, stall_last, stall_data});
        if (bus.ct_valid && bus.ct_ready) begin
            ct_cnt++;
            last_ct_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ct_extra: got %0h expected no byte", {bus.ct_last, bus.ct_data});
            end else begin
                e = exp_q.pop_front();
                chk("ct", {23'b0, bus.ct_last, bus.ct_data}, {23'b0, e});
            end
        end
        stall_prev = !rst && bus.ct_valid && !bus.ct_ready;
        stall_data = bus.ct_data;
        stall_last = bus.ct_last;
    end

    // Source/sink driver: updates inputs 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (ks_hs && ks_q.size() != 0) void'(ks_q.pop_front());
        if (pt_hs && pt_q.size() != 0) void'(pt_q.pop_front());
        bus.ks_valid = ks_q.size() != 0 && (full_rate || $urandom_range(0, 3) != 0);
        bus.ks_data  = ks_q.size() != 0 ? ks_q[0] : 8'($urandom);
        bus.pt_valid = pt_en && pt_q.size() != 0 && (full_rate || $urandom_range(0, 3) != 0);
        bus.pt_data  = pt_q.size() != 0 ? pt_q[0] : 8'($urandom);
        bus.ct_ready = !ct_hold && (full_rate || $urandom_range(0, 3) != 0);
    end

    task automatic fill_rand(input int len, input int drop);
        stg_ks.delete();
        stg_pt.delete();
        for (int i = 0; i < drop + len + 2; i++) stg_ks.push_back(8'($urandom));
        for (int i = 0; i < len; i++) stg_pt.push_back(8'($urandom));
    endtask

    task automatic begin_msg(input int len, input int drop);
        for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, stg_pt[i] ^ stg_ks[drop + i]});
        @(posedge clk);
        #1;
        foreach (stg_ks[i]) ks_q.push_back(stg_ks[i]);
        foreach (stg_pt[i]) pt_q.push_back(stg_pt[i]);
        ks_cnt = 0;
        pt_cnt = 0;
        ct_cnt = 0;
        rdy_seen = 1'b0;
        d0 = done_cnt;
        start_cyc = cyc;
        bus.start = 1'b1;
        bus.msg_len = 16'(len);
        bus.drop_n = 16'(drop);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.msg_len = 16'($urandom);
        bus.drop_n = 16'($urandom);
        if (len != 0) begin
            @(posedge clk);
            #1;
            bus.start = 1'b1;
            bus.msg_len = 16'($urandom_range(1, 40));
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
    endtask

    task automatic finish_msg(input int len, input int drop);
        for (int t = 0; t < 3000 && done_cnt == d0; t++) @(posedge clk);
        if (done_cnt == d0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done pulse expected one (len %0d)", len);
        end else if (len == 0) chk("done_lat0", done_cyc - start_cyc, 2);
        else chk("done_lat", done_cyc - last_ct_cyc, 1);
        repeat (2) @(posedge clk);
        #2;
        chk("done_pulses", done_cnt - d0, 1);
        chk("ks_xfers", ks_cnt, len == 0 ? 0 : drop + len);
        chk("pt_xfers", pt_cnt, len);
        chk("exp_left", exp_q.size(), 0);
        chk("idle_out", {30'b0, bus.busy, bus.ks_ready}, 0);
        if (len == 0) chk("rdy_len0", {31'b0, rdy_seen}, 0);
        ks_q.delete();
        pt_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, drop;
        bus.start = 1'b0;
        bus.msg_len = '0;
        bus.drop_n = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out", {18'b0, bus.ks_ready, bus.pt_ready, bus.ct_valid, bus.ct_data, bus.ct_last, bus.busy, bus.done}, 0);
        rst = 1'b0;
        stg_ks = {8'hA5, 8'h3C, 8'hFF, 8'h77, 8'h88};
        stg_pt = {8'h00, 8'h3C, 8'h0F};
        begin_msg(3, 0);
        finish_msg(3, 0);
        stg_ks = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        stg_pt = {8'h00, 8'h00};
        begin_msg(2, 2);
        finish_msg(2, 2);
        full_rate = 1'b1;
        pt_en = 1'b0;
        fill_rand(8, 0);
        begin_msg(8, 0);
        repeat (10) @(posedge clk);
        #2;
        chk("ks_fill", ks_cnt, 4);
        chk("ks_ready_full", {31'b0, bus.ks_ready}, 0);
        ct_hold = 1'b1;
        pt_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        cap = {bus.ct_valid, bus.ct_data};
        chk("stall_valid", {31'b0, bus.ct_valid}, 1);
        repeat (5) @(posedge clk);
        #2;
        chk("stall_data", {23'b0, bus.ct_valid, bus.ct_data}, {23'b0, cap});
        ct_hold = 1'b0;
        full_rate = 1'b0;
        finish_msg(8, 0);
        fill_rand(0, 5);
        begin_msg(0, 5);
        finish_msg(0, 5);
        fill_rand(5, 0);
        begin_msg(5, 0);
        for (int t = 0; t < 500 && ct_cnt < 2; t++) @(posedge clk);
        chk("pre_abort_ct", {31'b0, ct_cnt >= 2}, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out", {18'b0, bus.ks_ready, bus.pt_ready, bus.ct_valid, bus.ct_data, bus.ct_last, bus.busy, bus.done}, 0);
        d0 = done_cnt;
        ks_q.delete();
        pt_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        fill_rand(5, 3);
        begin_msg(5, 3);
        finish_msg(5, 3);
        for (int n = 0; n < 20; n++) begin
            len = $urandom_range(1, 20);
            drop = $urandom_range(0, 6);
            fill_rand(len, drop);
            begin_msg(len, drop);
            finish_msg(len, drop);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
